// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared constants and types for the instruction-fetch slice.
//   XLEN          datapath / address width
//   INST_NOP      instruction presented for a misaligned-redirect trap
//   S_RUN/S_TRAP  fetch FSM encodings
//   fetch_entry_t one buffered response: {pc, inst}
package fetch_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_TRAP = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: fetch-to-decode valid/ready channel.
//   out_valid      master->slave  out_pc/out_inst hold a valid instruction
//   out_ready      slave->master  decode accepts this cycle
//   out_pc         master->slave  address of out_inst
//   out_inst       master->slave  instruction word
//   out_misaligned master->slave  present only with FETCH_MISALIGN_EN
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;
`ifdef FETCH_MISALIGN_EN
  logic            out_misaligned;

  modport master (output out_valid, out_pc, out_inst, out_misaligned, input out_ready);
  modport slave  (input out_valid, out_pc, out_inst, out_misaligned, output out_ready);
`else
  modport master (output out_valid, out_pc, out_inst, input out_ready);
  modport slave  (input out_valid, out_pc, out_inst, output out_ready);
`endif
endinterface

// File: rtl/fetch_ctrl_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of {pc, inst} fetch responses.
//   clk, reset   clock, synchronous active-high reset
//   push_i       write push_data_i at the tail
//   pop_i        drop the head entry (ignored when empty)
//   clear_i      empty the FIFO; wins over push
//   head_o       current head entry
//   count_o      number of valid entries
module fetch_fifo
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  fetch_entry_t                 push_data_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  output fetch_entry_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop_i & (count_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // Zeroed storage makes the head read as pc=0/inst=0 out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer in front of a 1-cycle-latency imem.
// Owns the fetch PC, issues one read per cycle while FIFO credit allows, buffers
// responses in fetch_fifo and handles redirects with a full flush.
// Optional feature macro: FETCH_MISALIGN_EN (misaligned redirect traps instead
// of being force-aligned).
//   clk, reset      clock, synchronous active-high reset
//   imem_addr       byte address to imem (the fetch PC register)
//   imem_rdata      imem data for the address presented last cycle
//   redirect_valid  flush and restart at redirect_pc
//   redirect_pc     new fetch address
//   out_if          fetch_ctrl_if.master towards decode
//
// state  | meaning
// S_RUN  | normal fetching
// S_TRAP | misaligned redirect reported, fetch halted until next redirect
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  fetch_ctrl_if.master      out_if
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [0:0]       state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic [XLEN-1:0]  redirect_tgt;
  logic [CW-1:0]    fifo_count;
  fetch_entry_t     fifo_head, fifo_push_data;
  logic             fifo_pop, out_hs, issue;
  logic [CW:0]      credit_used;

`ifdef FETCH_MISALIGN_EN
  logic [XLEN-1:0]  trap_pc_q, trap_pc_d;
  logic             trap_pend_q, trap_pend_d;
  logic             redirect_mis;

  assign redirect_tgt = redirect_pc;
  assign redirect_mis = redirect_pc[1:0] != 2'b00;
`else
  logic             unused_redirect_lsb;

  assign redirect_tgt        = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

  assign out_hs   = out_if.out_valid & out_if.out_ready;
  assign fifo_pop = out_hs & (state_q == S_RUN);

  // Entries held plus the one in flight, after this cycle's pop, must leave room.
  assign credit_used = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(fifo_pop);
  assign issue = (state_q == S_RUN) & ~redirect_valid & (credit_used < (CW+1)'(DEPTH));

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
`ifdef FETCH_MISALIGN_EN
    trap_pc_d     = trap_pc_q;
    trap_pend_d   = trap_pend_q;
    if (state_q == S_TRAP && out_if.out_ready) trap_pend_d = 1'b0;
`endif
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
`ifdef FETCH_MISALIGN_EN
      if (redirect_mis) begin
        state_d     = S_TRAP;
        trap_pc_d   = redirect_pc;
        trap_pend_d = 1'b1;
      end else begin
        state_d = S_RUN;
      end
`endif
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_RUN;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      trap_pc_q     <= '0;
      trap_pend_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
`ifdef FETCH_MISALIGN_EN
      trap_pc_q     <= trap_pc_d;
      trap_pend_q   <= trap_pend_d;
`endif
    end
  end

  assign fifo_push_data = '{pc: inflight_pc_q, inst: imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (fifo_push_data),
    .pop_i       (fifo_pop),
    .clear_i     (redirect_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign imem_addr = fetch_pc_q;

`ifdef FETCH_MISALIGN_EN
  always_comb begin
    if (state_q == S_TRAP) begin
      out_if.out_valid      = trap_pend_q;
      out_if.out_pc         = trap_pc_q;
      out_if.out_inst       = INST_NOP;
      out_if.out_misaligned = 1'b1;
    end else begin
      out_if.out_valid      = fifo_count != '0;
      out_if.out_pc         = fifo_head.pc;
      out_if.out_inst       = fifo_head.inst;
      out_if.out_misaligned = 1'b0;
    end
  end
`else
  assign out_if.out_valid = fifo_count != '0;
  assign out_if.out_pc    = fifo_head.pc;
  assign out_if.out_inst  = fifo_head.inst;
`endif

endmodule
